// File: rtl/cpu_mbus_pkg.sv
// Shared types for the cpu_mbus accumulator CPU.
//   opcode_t : 3-bit instruction opcode held in the top bits of the IR
//   state_t  : sequencer state, also exported on cpu_mbus.dbg_state
package cpu_mbus_pkg;

  localparam int OPC_WIDTH = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM    = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_mbus_alu.sv
// Combinational accumulator ALU.
//   i_op : opcode selecting the function (ADD, AND, XOR, LDA pass-through)
//   i_a  : accumulator value
//   i_b  : operand fetched from memory
//   o_y  : result; ADD wraps modulo 2^DATA_WIDTH, the carry is dropped
module alu
  import cpu_mbus_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  opcode_t               i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_b;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = i_b;  // LDA, and a harmless value for the rest
    endcase
  end

endmodule

// File: rtl/cpu_mbus.sv
// Multi-cycle accumulator CPU with a single request/acknowledge memory bus.
//   clk_       : sole clock, rising edge
//   rst        : synchronous active-high reset
//   cont       : one-cycle pulse that leaves HALT
//   mem_req    : bus request; mem_we/mem_addr/mem_wdata are valid with it
//   mem_ack    : completes the transfer in a cycle where mem_req is also 1
//   mem_rdata  : read data, sampled only in the ack cycle of a read
//   halt       : 1 in the HALT state
//   pc_out     : current program counter
//   dbg_state  : current sequencer state
//
// Bus handshake: mem_req acts as valid and mem_ack as ready. A transfer
// happens exactly in a cycle with mem_req=1 and mem_ack=1. Once raised,
// mem_req and its qualifiers stay unchanged until that cycle (the state
// cannot leave FETCH/MEM without ack). mem_ack seen with mem_req=0 is ignored.
module cpu_mbus
  import cpu_mbus_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_,
  input  logic                  rst,
  input  logic                  cont,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output state_t                dbg_state
);

  // The opcode and operand address must fit side by side in one word.
  if (DATA_WIDTH < ADDR_WIDTH + OPC_WIDTH) begin : g_width_check
    $error("cpu_mbus: DATA_WIDTH must be at least ADDR_WIDTH+3");
  end

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_ir;
  logic [DATA_WIDTH-1:0] r_opnd;

  opcode_t               w_opc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_alu;
  logic                  w_unused_ir;

  assign w_opc  = opcode_t'(r_ir[DATA_WIDTH-1 -: OPC_WIDTH]);
  assign w_addr = r_ir[ADDR_WIDTH-1:0];
  // Bits between the opcode and the address field carry no meaning.
  assign w_unused_ir = ^r_ir;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_op (w_opc),
    .i_a  (r_acc),
    .i_b  (r_opnd),
    .o_y  (w_alu)
  );

  always_ff @(posedge clk_) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_acc   <= '0;
      r_ir    <= '0;
      r_opnd  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ack) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + ADDR_WIDTH'(1);
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (w_opc)
            OP_HLT: r_state <= S_HALT;
            OP_SKZ: begin
              // pc already points past SKZ; one more step skips the next word
              if (r_acc == '0) r_pc <= r_pc + ADDR_WIDTH'(1);
              r_state <= S_FETCH;
            end
            OP_JMP: begin
              r_pc    <= w_addr;
              r_state <= S_FETCH;
            end
            default: r_state <= S_MEM;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (w_opc == OP_STO) begin
              r_state <= S_FETCH;
            end else begin
              r_opnd  <= mem_rdata;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_acc   <= w_alu;
          r_state <= S_FETCH;
        end
        S_HALT: begin
          if (cont) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Bus outputs decode straight from the state register. mem_req is also
  // gated by rst so a pending request drops while reset is held.
  assign mem_req   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !rst;
  assign mem_we    = (r_state == S_MEM) && (w_opc == OP_STO) && !rst;
  assign mem_addr  = (r_state == S_MEM) ? w_addr : r_pc;
  assign mem_wdata = r_acc;
  assign halt      = (r_state == S_HALT);
  assign pc_out    = r_pc;
  assign dbg_state = r_state;

endmodule
